// File: rtl/ram_burst_master.sv
// ram_burst_master: drives a falling-edge synchronous RAM with single or burst
// read/write transactions of up to 8 beats at consecutive (wrapping) addresses.
// Optional feature macro: RAM_BURST_MASTER_BURST_EN -- when defined, burst_len
// selects 1..8 beats; when undefined every transaction is a single beat.
module ram_burst_master #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              write,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [2:0]        burst_len,
  output logic              busy,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              done,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_we,
  output logic              ram_chip_select,
  input  logic [DATA_W-1:0] ram_data_out
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;        // next beat address to issue
  logic [2:0]        left, left_nxt;        // beats still to issue after the current one
  logic [2:0]        first_len;
  logic              cs_nxt, we_nxt, rvld_nxt;
  logic [ADDR_W-1:0] ram_addr_nxt;
  logic [DATA_W-1:0] ram_din_nxt, rdata_nxt;

`ifdef RAM_BURST_MASTER_BURST_EN
  assign first_len = burst_len;
`else
  logic unused_burst_len;
  assign unused_burst_len = ^burst_len;
  assign first_len        = 3'd0;
`endif

  assign busy        = (state != IDLE);
  assign wdata_ready = (state == WRITE);
  // DONE lasts exactly one cycle, which is the completion pulse.
  assign done        = (state == DONE);

  // State register; reset abandons any burst in progress.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and next-register logic for the transaction sequencer.
  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr;
    left_nxt     = left;
    cs_nxt       = 1'b0;
    we_nxt       = 1'b0;
    rvld_nxt     = 1'b0;
    ram_addr_nxt = ram_address;
    ram_din_nxt  = ram_data_in;
    rdata_nxt    = rdata;
    case (state)
      IDLE: begin
        if (req) begin
          left_nxt     = first_len;
          ram_addr_nxt = start_addr;
          if (write) begin
            state_nxt = WRITE;
            addr_nxt  = start_addr;
          end else begin
            // Beat 0 of a read goes out on the accept edge itself.
            state_nxt = READ;
            cs_nxt    = 1'b1;
            addr_nxt  = start_addr + 1'b1;
          end
        end
      end
      WRITE: begin
        // A stall leaves chip select low and the last address on the bus.
        if (wdata_valid) begin
          cs_nxt       = 1'b1;
          we_nxt       = 1'b1;
          ram_addr_nxt = addr;
          ram_din_nxt  = wdata;
          addr_nxt     = addr + 1'b1;
          if (left == 3'd0) state_nxt = DONE;
          else              left_nxt  = left - 3'd1;
        end
      end
      READ: begin
        // The RAM answered the previous beat on the falling edge; capture it.
        rdata_nxt = ram_data_out;
        rvld_nxt  = 1'b1;
        if (left == 3'd0) begin
          state_nxt = DONE;
        end else begin
          cs_nxt       = 1'b1;
          ram_addr_nxt = addr;
          addr_nxt     = addr + 1'b1;
          left_nxt     = left - 3'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered RAM drive and read capture; all cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      ram_chip_select <= 1'b0;
      ram_we          <= 1'b0;
      ram_address     <= '0;
      ram_data_in     <= '0;
      rdata           <= '0;
      rdata_valid     <= 1'b0;
    end else begin
      ram_chip_select <= cs_nxt;
      ram_we          <= we_nxt;
      ram_address     <= ram_addr_nxt;
      ram_data_in     <= ram_din_nxt;
      rdata           <= rdata_nxt;
      rdata_valid     <= rvld_nxt;
    end
  end

  // Beat address and beat counter; always reloaded on accept, so no reset.
  always_ff @(posedge clock) begin
    addr <= addr_nxt;
    left <= left_nxt;
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// Testbench for ram_burst_master with a falling-edge RAM model and a
// scoreboard of expected RAM accesses and read data.
`timescale 1ns/1ps
module tb_ram_burst_master;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
`ifdef RAM_BURST_MASTER_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              req = 1'b0;
  logic              write = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [2:0]        burst_len = '0;
  logic              busy;
  logic [DATA_W-1:0] wdata = '0;
  logic              wdata_valid = 1'b0;
  logic              wdata_ready;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              done;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data_in;
  logic              ram_we;
  logic              ram_chip_select;
  logic [DATA_W-1:0] ram_data_out;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } acc_t;

  acc_t              exp_acc[$];
  logic [DATA_W-1:0] exp_rd[$];
  logic [DATA_W-1:0] shadow [32] = '{default: '0};
  logic [DATA_W-1:0] mem    [32] = '{default: '0};

  ram_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset), .req(req), .write(write),
    .start_addr(start_addr), .burst_len(burst_len), .busy(busy),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .done(done),
    .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_we(ram_we),
    .ram_chip_select(ram_chip_select), .ram_data_out(ram_data_out)
  );

  always #5 clock = ~clock;

  // RAM model acting on the falling edge
  always @(negedge clock) begin
    if (ram_chip_select === 1'b1) begin
      if (ram_we === 1'b1) mem[ram_address] <= ram_data_in;
      else                 ram_data_out     <= mem[ram_address];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int nbeats(input logic [2:0] len);
    return BURST_EN ? int'(len) + 1 : 1;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_burst(input logic [ADDR_W-1:0] a, input logic [2:0] len,
                             input logic [15:0] pat, input logic [DATA_W-1:0] base,
                             input string tag);
    int n, k, i;
    acc_t e;
    logic [ADDR_W-1:0] held;
    n = nbeats(len);
    exp_acc.delete();
    req = 1'b1; write = 1'b1; start_addr = a; burst_len = len; wdata_valid = 1'b0;
    tick();
    req = 1'b0; write = 1'b0;
    total++;
    if (busy !== 1'b1 || wdata_ready !== 1'b1 || ram_chip_select !== 1'b0) begin
      bad++;
      $display("FAIL %s_enter busy=%b ready=%b cs=%b required 1 1 0", tag, busy, wdata_ready, ram_chip_select);
    end
    k = 0; i = 0;
    while (k < n && i < 24) begin
      wdata_valid = (i < 16) ? pat[i[3:0]] : 1'b1;
      wdata = base + DATA_W'(k);
      if (wdata_valid) begin
        e.we = 1'b1; e.addr = a + ADDR_W'(k); e.data = base + DATA_W'(k);
        exp_acc.push_back(e);
        shadow[e.addr] = e.data;
        k++;
      end
      tick();
      i++;
      total++;
      if (ram_chip_select === 1'b1) begin
        if (exp_acc.size() == 0) begin
          bad++;
          $display("FAIL %s_extra_access addr=%0d required no access", tag, ram_address);
        end else begin
          e = exp_acc.pop_front();
          if (ram_we !== e.we || ram_address !== e.addr || ram_data_in !== e.data) begin
            bad++;
            $display("FAIL %s_beat we=%b addr=%0d data=%h required we=%b addr=%0d data=%h",
                     tag, ram_we, ram_address, ram_data_in, e.we, e.addr, e.data);
          end
        end
      end else begin
        held = (k == 0) ? a : a + ADDR_W'(k - 1);
        if (wdata_valid !== 1'b0 || ram_address !== held || wdata_ready !== 1'b1) begin
          bad++;
          $display("FAIL %s_stall cs=0 valid=%b addr=%0d ready=%b required valid=0 addr=%0d ready=1",
                   tag, wdata_valid, ram_address, wdata_ready, held);
        end
      end
      total++;
      if (done !== (k == n)) begin
        bad++;
        $display("FAIL %s_done done=%b required %b", tag, done, (k == n));
      end
    end
    wdata_valid = 1'b0;
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || ram_chip_select !== 1'b0 || ram_we !== 1'b0 || wdata_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s_after done=%b busy=%b cs=%b we=%b ready=%b required all 0",
               tag, done, busy, ram_chip_select, ram_we, wdata_ready);
    end
    total++;
    if (exp_acc.size() != 0) begin
      bad++;
      $display("FAIL %s_pending missing_beats=%0d required 0", tag, exp_acc.size());
    end
  endtask

  task automatic read_burst(input logic [ADDR_W-1:0] a, input logic [2:0] len,
                            input bit inject, input int reset_at, input string tag);
    int n, issue, caps, ac, rv, dn, first_ac, last_ac, first_rv, last_rv, done_cyc;
    bit rst_case;
    acc_t e;
    logic [DATA_W-1:0] r;
    n = nbeats(len);
    rst_case = (reset_at >= 0) && (reset_at < n);
    issue = rst_case ? reset_at + 1 : n;
    caps  = rst_case ? reset_at : n;
    exp_acc.delete();
    exp_rd.delete();
    for (int k = 0; k < issue; k++) begin
      e.we = 1'b0; e.addr = a + ADDR_W'(k); e.data = '0;
      exp_acc.push_back(e);
    end
    for (int k = 0; k < caps; k++) exp_rd.push_back(shadow[a + ADDR_W'(k)]);
    ac = 0; rv = 0; dn = 0;
    first_ac = -1; last_ac = -1; first_rv = -1; last_rv = -1; done_cyc = -1;
    req = 1'b1; write = 1'b0; start_addr = a; burst_len = len;
    tick();
    req = 1'b0;
    for (int cyc = 0; cyc < n + 4; cyc++) begin
      if (ram_chip_select === 1'b1) begin
        total++;
        if (exp_acc.size() == 0) begin
          bad++;
          $display("FAIL %s_extra_access cyc=%0d addr=%0d we=%b required no access", tag, cyc, ram_address, ram_we);
        end else begin
          e = exp_acc.pop_front();
          if (ram_we !== 1'b0 || ram_address !== e.addr) begin
            bad++;
            $display("FAIL %s_beat cyc=%0d we=%b addr=%0d required we=0 addr=%0d", tag, cyc, ram_we, ram_address, e.addr);
          end
        end
        ac++;
        if (first_ac < 0) first_ac = cyc;
        last_ac = cyc;
      end
      if (rdata_valid === 1'b1) begin
        total++;
        if (exp_rd.size() == 0) begin
          bad++;
          $display("FAIL %s_extra_rdata cyc=%0d rdata=%h required no rdata_valid", tag, cyc, rdata);
        end else begin
          r = exp_rd.pop_front();
          if (rdata !== r) begin
            bad++;
            $display("FAIL %s_rdata cyc=%0d rdata=%h required %h", tag, cyc, rdata, r);
          end
        end
        rv++;
        if (first_rv < 0) first_rv = cyc;
        last_rv = cyc;
      end
      if (done === 1'b1) begin
        dn++;
        done_cyc = cyc;
      end
      if (rst_case && cyc == reset_at + 1) begin
        total++;
        if ({busy, wdata_ready, rdata_valid, done, ram_chip_select, ram_we} !== 6'b0 ||
            rdata !== '0 || ram_address !== '0 || ram_data_in !== '0) begin
          bad++;
          $display("FAIL %s_reset_outputs ctrl=%b rdata=%h addr=%0d din=%h required all 0", tag,
                   {busy, wdata_ready, rdata_valid, done, ram_chip_select, ram_we}, rdata, ram_address, ram_data_in);
        end
      end
      req        = inject && (cyc == 1);
      write      = inject && (cyc == 1);
      start_addr = (inject && cyc == 1) ? a + 5'd9 : a;
      reset      = rst_case && (cyc == reset_at);
      tick();
    end
    reset = 1'b0;
    req = 1'b0; write = 1'b0;
    total++;
    if (exp_acc.size() != 0 || exp_rd.size() != 0) begin
      bad++;
      $display("FAIL %s_pending beats=%0d rdata=%0d required 0 0", tag, exp_acc.size(), exp_rd.size());
    end
    total++;
    if (dn != (rst_case ? 0 : 1)) begin
      bad++;
      $display("FAIL %s_done_count done_pulses=%0d required %0d", tag, dn, rst_case ? 0 : 1);
    end
    if (!rst_case) begin
      total++;
      if (first_ac != 0 || last_ac != n - 1 || ac != n || first_rv != 1 || last_rv != n || rv != n || done_cyc != n) begin
        bad++;
        $display("FAIL %s_timing acc=%0d..%0d rv=%0d..%0d done=%0d required acc=0..%0d rv=1..%0d done=%0d",
                 tag, first_ac, last_ac, first_rv, last_rv, done_cyc, n - 1, n, n);
      end
    end
    total++;
    if (busy !== 1'b0 || ram_chip_select !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle busy=%b cs=%b required 0 0", tag, busy, ram_chip_select);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b1; write = 1'b0; start_addr = 5'd3; burst_len = 3'd2;
    tick();
    tick();
    total++;
    if ({busy, wdata_ready, rdata_valid, done, ram_chip_select, ram_we} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b required 000000", {busy, wdata_ready, rdata_valid, done, ram_chip_select, ram_we});
    end
    total++;
    if (rdata !== '0 || ram_address !== '0 || ram_data_in !== '0) begin
      bad++;
      $display("FAIL reset_data rdata=%h addr=%0d din=%h required 0", rdata, ram_address, ram_data_in);
    end
    reset = 1'b0; req = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || ram_chip_select !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle busy=%b cs=%b required 0 0", busy, ram_chip_select);
    end
  endtask

  task automatic test_fill();
    for (int j = 0; j < 32; j++)
      write_burst(ADDR_W'(j), 3'd0, 16'hFFFF, 32'hA5000000 + DATA_W'(j * 32'h01010101), "fill");
  endtask

  task automatic test_single_write();
    write_burst(5'd5, 3'd0, 16'hFFFF, 32'hDEADBEEF, "single_wr");
    total++;
    if (mem[5] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL single_wr_ram ram5=%h required deadbeef", mem[5]);
    end
    read_burst(5'd5, 3'd0, 1'b0, -1, "single_rd");
  endtask

  task automatic test_read_wrap();
    write_burst(5'd30, 3'd0, 16'hFFFF, 32'h11, "pre30");
    write_burst(5'd31, 3'd0, 16'hFFFF, 32'h22, "pre31");
    write_burst(5'd0,  3'd0, 16'hFFFF, 32'h33, "pre0");
    write_burst(5'd1,  3'd0, 16'hFFFF, 32'h44, "pre1");
    read_burst(5'd30, 3'd3, 1'b0, -1, "read_wrap");
  endtask

  task automatic test_write_stall();
    write_burst(5'd10, 3'd2, 16'hFFFD, 32'h1000_0000, "wr_stall");
    write_burst(5'd28, 3'd3, 16'hFFFC, 32'h2000_0000, "wr_stall_wrap");
    read_burst(5'd10, 3'd2, 1'b0, -1, "stall_readback");
    read_burst(5'd28, 3'd3, 1'b0, -1, "wrap_readback");
  endtask

  task automatic test_busy_req();
    read_burst(5'd0, 3'd7, 1'b1, -1, "busy_req");
  endtask

  task automatic test_reset_mid_burst();
    read_burst(5'd20, 3'd7, 1'b0, BURST_EN ? 2 : 0, "reset_mid");
    read_burst(5'd3, 3'd1, 1'b0, -1, "after_reset");
  endtask

  task automatic test_single_beat();
    read_burst(5'd12, 3'd7, 1'b0, -1, "len7_read");
    write_burst(5'd7, 3'd0, 16'hFFFF, 32'hCAFE0007, "len0_write");
  endtask

  initial begin
    test_reset();
    test_fill();
    test_single_write();
    test_read_wrap();
    test_write_stall();
    test_busy_req();
    test_reset_mid_burst();
    test_single_beat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
